// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-masked word RAM behind the memory stage with fixed wait states and a pipeline stall.
module data_mem_ctrl #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        request,
    input  logic        we_re,
    input  logic [3:0]  mask,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        valid,
    output logic        stall
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t                  state, state_n;
    logic [3:0]              cnt, cnt_n;
    logic                    lat_we;
    logic [3:0]              lat_mask;
    logic [ADDR_WIDTH-1:0]   lat_idx;
    logic [31:0]             lat_data;
    logic [31:0]             ram [2**ADDR_WIDTH];
    logic                    accept, commit, c_we;
    logic [3:0]              c_mask;
    logic [ADDR_WIDTH-1:0]   c_idx;
    logic [31:0]             c_data;
    logic                    unused_addr;
    assign unused_addr = ^{address[31:ADDR_WIDTH+2], address[1:0]};
    assign accept = state == IDLE && request;
    assign valid  = state == RESP;
    assign stall  = !rst && (accept || state == WAIT);
    always_comb begin
        state_n = accept ? (WAIT_STATES > 0 ? WAIT : RESP) :
                  state == WAIT ? (cnt == 4'd1 ? RESP : WAIT) :
                  state == RESP ? IDLE : state;
        cnt_n   = accept ? 4'(WAIT_STATES) : state == WAIT ? cnt - 4'd1 : cnt;
    end
    // With no wait states the commit happens on the accept edge, before the fields are latched.
    assign commit = state_n == RESP && state != RESP;
    assign c_we   = state == IDLE ? we_re : lat_we;
    assign c_mask = state == IDLE ? mask : lat_mask;
    assign c_idx  = state == IDLE ? address[ADDR_WIDTH+1:2] : lat_idx;
    assign c_data = state == IDLE ? store_data : lat_data;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_mask  <= '0;
            lat_idx   <= '0;
            lat_data  <= '0;
            load_data <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                lat_we   <= we_re;
                lat_mask <= mask;
                lat_idx  <= address[ADDR_WIDTH+1:2];
                lat_data <= store_data;
            end
            if (commit && !c_we)
                load_data <= ram[c_idx];
        end
    end
    // RAM is not reset; rst only blocks a commit that coincides with it.
    always_ff @(posedge clk) begin
        if (commit && c_we && !rst)
            for (int i = 0; i < 4; i++)
                if (c_mask[i])
                    ram[c_idx][8*i +: 8] <= c_data[8*i +: 8];
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: three controllers (1, 0 and 3 wait states) checked against a word-array model.
module tb_data_mem_ctrl;
    localparam int WS[3] = '{1, 0, 3};
    logic        clk = 1'b0;
    logic        rst;
    logic        req [3];
    logic        we_r [3];
    logic [3:0]  msk [3];
    logic [31:0] addr [3];
    logic [31:0] sd [3];
    logic [31:0] ld [3];
    logic        vld [3];
    logic        stl [3];
    logic [31:0] mem_m [3][1024];
    logic [31:0] ld_m [3];
    int          n_chk = 0;
    int          n_fail = 0;
    int          pool [8] = '{3, 4, 16, 100, 511, 512, 700, 1023};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_mem_ctrl #(.ADDR_WIDTH(10), .WAIT_STATES(WS[g])) u_dut (
            .clk(clk), .rst(rst), .request(req[g]), .we_re(we_r[g]), .mask(msk[g]),
            .address(addr[g]), .store_data(sd[g]), .load_data(ld[g]), .valid(vld[g]), .stall(stl[g])
        );
    end

    typedef struct {
        int          k;
        bit          we;
        logic [3:0]  m;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [13];

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst=%0d t=%0t: got %h expected %h", nm, k, $time, act, exp);
        end
    endtask

    task automatic scramble(input int k, input bit hold);
        req[k]  = hold ? 1'b1 : 1'($urandom_range(0, 1));
        we_r[k] = 1'($urandom_range(0, 1));
        msk[k]  = 4'($urandom());
        addr[k] = $urandom();
        sd[k]   = $urandom();
    endtask

    // One full access: accept, WS wait cycles, response; fields are scrambled after acceptance.
    task automatic access(input int k, input bit we, input logic [3:0] m, input logic [31:0] a,
                          input logic [31:0] d, input bit hold, input bit use_exp, input logic [31:0] exp);
        int idx = int'(a[11:2]);
        @(negedge clk);
        req[k] = 1'b1; we_r[k] = we; msk[k] = m; addr[k] = a; sd[k] = d;
        #1;
        chk("stall_accept", k, 32'(stl[k]), 32'd1);
        chk("valid_accept", k, 32'(vld[k]), 32'd0);
        for (int c = 1; c <= WS[k]; c++) begin
            @(negedge clk);
            scramble(k, hold);
            #1;
            chk("stall_wait", k, 32'(stl[k]), 32'd1);
            chk("valid_wait", k, 32'(vld[k]), 32'd0);
        end
        @(negedge clk);
        scramble(k, hold);
        req[k] = hold;
        #1;
        if (we) begin
            for (int i = 0; i < 4; i++)
                if (m[i]) mem_m[k][idx][8*i +: 8] = d[8*i +: 8];
        end else begin
            ld_m[k] = mem_m[k][idx];
        end
        chk("stall_resp", k, 32'(stl[k]), 32'd0);
        chk("valid_resp", k, 32'(vld[k]), 32'd1);
        chk("load_model", k, ld[k], ld_m[k]);
        if (use_exp) chk("load_expected", k, ld[k], exp);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tbl = '{
            '{0, 1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0},
            '{0, 1'b0, 4'h0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF},
            '{0, 1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344, 32'h0},
            '{0, 1'b1, 4'h2, 32'h0000_0020, 32'h0000_AA00, 32'h0},
            '{0, 1'b1, 4'hC, 32'h0000_0020, 32'hBBBB_0000, 32'h0},
            '{0, 1'b0, 4'h0, 32'h0000_0020, 32'h0,         32'hBBBB_AA44},
            '{0, 1'b1, 4'hF, 32'h0000_0008, 32'h0000_0055, 32'h0},
            '{0, 1'b0, 4'h0, 32'h0000_1008, 32'h0,         32'h0000_0055},
            '{1, 1'b1, 4'hF, 32'h0000_1000, 32'hCAFE_F00D, 32'h0},
            '{1, 1'b0, 4'h0, 32'h0000_1003, 32'h0,         32'hCAFE_F00D},
            '{1, 1'b0, 4'h0, 32'h0000_0000, 32'h0,         32'hCAFE_F00D},
            '{2, 1'b1, 4'hF, 32'h0000_0040, 32'h1234_5678, 32'h0},
            '{2, 1'b0, 4'h0, 32'h0000_0040, 32'h0,         32'h1234_5678}
        };
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req[k] = 1'b0; we_r[k] = 1'b0; msk[k] = '0; addr[k] = '0; sd[k] = '0; ld_m[k] = '0;
        end
        req[0] = 1'b1;
        #2;
        for (int k = 0; k < 3; k++) begin
            chk("reset_stall", k, 32'(stl[k]), 32'd0);
            chk("reset_valid", k, 32'(vld[k]), 32'd0);
            chk("reset_load", k, ld[k], 32'h0);
        end
        req[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[r])
            access(tbl[r].k, tbl[r].we, tbl[r].m, tbl[r].a, tbl[r].d, 1'b0, !tbl[r].we, tbl[r].exp);

        // Request held through RESP: a mask-0000 store, then an immediate read of the same word.
        access(0, 1'b1, 4'h0, 32'h0000_0010, 32'h0BAD_0BAD, 1'b1, 1'b0, 32'h0);
        access(0, 1'b0, 4'h0, 32'h0000_0010, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);

        // Reset in the second wait cycle of a 3-wait-state store.
        @(negedge clk);
        req[2] = 1'b1; we_r[2] = 1'b1; msk[2] = 4'hF; addr[2] = 32'h40; sd[2] = 32'hFFFF_FFFF;
        #1;
        chk("rw_stall_accept", 2, 32'(stl[2]), 32'd1);
        @(negedge clk);
        req[2] = 1'b0;
        #1;
        chk("rw_stall_wait1", 2, 32'(stl[2]), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rw_stall", 2, 32'(stl[2]), 32'd0);
        chk("rw_valid", 2, 32'(vld[2]), 32'd0);
        chk("rw_load", 2, ld[2], 32'h0);
        chk("rw_load_other", 0, ld[0], 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) ld_m[k] = '0;
        access(2, 1'b0, 4'h0, 32'h0000_0040, 32'h0, 1'b0, 1'b1, 32'h1234_5678);

        // Randomized traffic over a small word pool on each instance.
        for (int k = 0; k < 3; k++) begin
            foreach (pool[p])
                access(k, 1'b1, 4'hF, 32'(pool[p]) << 2, $urandom(), 1'b0, 1'b0, 32'h0);
            for (int j = 0; j < 30; j++) begin
                logic [31:0] a;
                bit          h;
                a = ($urandom() & 32'hFFFF_F003) | (32'(pool[$urandom_range(0, 7)]) << 2);
                h = (j < 29) ? 1'($urandom_range(0, 1)) : 1'b0;
                access(k, 1'($urandom_range(0, 1)), 4'($urandom()), a, $urandom(), h, 1'b0, 32'h0);
            end
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
